// File: rtl/lsu_store_buffered_if.sv
`default_nettype none
//==============================================================================
// Module   : lsu_store_buffered_if
// Brief    : Data-memory command port between the LSU and the memory.
//            The master issues start/write commands with a word address,
//            write data and byte strobes; the slave answers with ready and,
//            for reads, a data beat flagged by mem_rdata_valid.
// Revision : 1.0 - initial release
//==============================================================================
interface lsu_store_buffered_if #(
    parameter int ADDR_W = 32
);
    logic              mem_cmd_start;
    logic              mem_cmd_write;
    logic              mem_cmd_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wstrb;
    logic [31:0]       mem_rdata;
    logic              mem_rdata_valid;

    modport master (
        output mem_cmd_start,
        output mem_cmd_write,
        output mem_addr,
        output mem_wdata,
        output mem_wstrb,
        input  mem_cmd_ready,
        input  mem_rdata,
        input  mem_rdata_valid
    );

    modport slave (
        input  mem_cmd_start,
        input  mem_cmd_write,
        input  mem_addr,
        input  mem_wdata,
        input  mem_wstrb,
        output mem_cmd_ready,
        output mem_rdata,
        output mem_rdata_valid
    );
endinterface
`default_nettype wire

// File: rtl/lsu_store_buffered.sv
`default_nettype none
//==============================================================================
// Module   : lsu_store_buffered
// Brief    : Memory-stage load/store unit. Stores are posted into a FIFO
//            store buffer and retire immediately; loads wait for the buffer
//            to drain, then run a REQ/DATA handshake. Byte-lane steering,
//            load extension and misaligned-access detection are done here.
// Revision : 1.0 - initial release
//==============================================================================
module lsu_store_buffered #(
    parameter int          SB_DEPTH  = 4,
    parameter int          ADDR_W    = 32,
    parameter logic [31:0] REGPC_NOP = 32'h0000_0000,
    parameter logic [31:0] INST_NOP  = 32'h0000_0013
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic [31:0]          in_pc,
    input  logic [31:0]          in_inst,
    input  logic [ADDR_W-1:0]    in_addr,
    input  logic [31:0]          in_wdata,
    input  logic [3:0]           in_mem_op,
    input  logic                 in_rf_wen,
    input  logic [3:0]           in_wb_sel,
    input  logic [4:0]           in_wb_addr,
    output logic                 stall,
    output logic                 out_valid,
    output logic [31:0]          out_pc,
    output logic [31:0]          out_inst,
    output logic [31:0]          out_alu_out,
    output logic [31:0]          out_rdata,
    output logic                 out_misaligned,
    output logic                 out_rf_wen,
    output logic [3:0]           out_wb_sel,
    output logic [4:0]           out_wb_addr,
    output logic                 sb_empty,
    output logic                 fwd_rf_wen,
    output logic [4:0]           fwd_wb_addr,
    lsu_store_buffered_if.master mem
);

    localparam int c_PTR_W = $clog2(SB_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    localparam logic [3:0] c_MEN_X   = 4'd0;
    localparam logic [3:0] c_MEN_SB  = 4'd1;
    localparam logic [3:0] c_MEN_SH  = 4'd2;
    localparam logic [3:0] c_MEN_SW  = 4'd3;
    localparam logic [3:0] c_MEN_LB  = 4'd4;
    localparam logic [3:0] c_MEN_LBU = 4'd5;
    localparam logic [3:0] c_MEN_LH  = 4'd6;
    localparam logic [3:0] c_MEN_LHU = 4'd7;
    localparam logic [3:0] c_MEN_LW  = 4'd8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DATA = 2'd2
    } state_t;

    // Picks the addressed byte/halfword out of a returned word and extends it.
    function automatic logic [31:0] f_extract(input logic [3:0]  op,
                                              input logic [1:0]  lane,
                                              input logic [31:0] word);
        logic [7:0]  v_byte;
        logic [15:0] v_half;
        v_byte = 8'(word >> {lane, 3'b000});
        v_half = lane[1] ? word[31:16] : word[15:0];
        case (op)
            c_MEN_LB:  f_extract = {{24{v_byte[7]}}, v_byte};
            c_MEN_LBU: f_extract = {24'h0, v_byte};
            c_MEN_LH:  f_extract = {{16{v_half[15]}}, v_half};
            c_MEN_LHU: f_extract = {16'h0, v_half};
            default:   f_extract = word;
        endcase
    endfunction

    // Store buffer state
    logic [ADDR_W-1:0]  r_sb_addr [SB_DEPTH];
    logic [31:0]        r_sb_data [SB_DEPTH];
    logic [3:0]         r_sb_strb [SB_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    // Load FSM and the load instruction held while it is in flight
    state_t            r_state;
    logic              r_discard;
    logic [31:0]       r_sv_pc;
    logic [31:0]       r_sv_inst;
    logic [ADDR_W-1:0] r_sv_addr;
    logic [3:0]        r_sv_op;
    logic              r_sv_rf_wen;
    logic [3:0]        r_sv_wb_sel;
    logic [4:0]        r_sv_wb_addr;

    logic w_in_valid;
    logic w_is_byte, w_is_half, w_is_word, w_is_store, w_is_load, w_is_mem;
    logic w_misaligned;
    logic w_idle, w_sb_empty, w_sb_full;
    logic w_acc_mis, w_acc_store, w_acc_load, w_acc_x, w_acc_direct, w_accept;
    logic w_pop;
    logic w_load_retire;
    logic [3:0]  w_st_strb;
    logic [31:0] w_st_data;
    logic [1:0]  w_lane;

    // A flushed instruction is treated as if it were never presented.
    assign w_in_valid = in_valid & ~flush;
    assign w_lane     = in_addr[1:0];

    // Decode the memory op into direction and access size.
    always_comb begin
        w_is_byte  = 1'b0;
        w_is_half  = 1'b0;
        w_is_word  = 1'b0;
        w_is_store = 1'b0;
        w_is_load  = 1'b0;
        case (in_mem_op)
            c_MEN_SB:  begin w_is_store = 1'b1; w_is_byte = 1'b1; end
            c_MEN_SH:  begin w_is_store = 1'b1; w_is_half = 1'b1; end
            c_MEN_SW:  begin w_is_store = 1'b1; w_is_word = 1'b1; end
            c_MEN_LB,
            c_MEN_LBU: begin w_is_load  = 1'b1; w_is_byte = 1'b1; end
            c_MEN_LH,
            c_MEN_LHU: begin w_is_load  = 1'b1; w_is_half = 1'b1; end
            c_MEN_LW:  begin w_is_load  = 1'b1; w_is_word = 1'b1; end
            default:   ;
        endcase
    end

    assign w_is_mem     = w_is_store | w_is_load;
    assign w_misaligned = (w_is_half & in_addr[0]) | (w_is_word & (w_lane != 2'b00));

    assign w_idle     = (r_state == S_IDLE);
    assign w_sb_empty = (r_count == '0);
    // Registered count only: a pop in the same cycle does not free a slot yet.
    assign w_sb_full  = (r_count == c_CNT_W'(SB_DEPTH));

    // All acceptance requires an idle FSM so a direct retire never collides
    // with a load retire on the output registers.
    assign w_acc_mis    = w_in_valid & w_idle & w_is_mem & w_misaligned;
    assign w_acc_store  = w_in_valid & w_idle & w_is_store & ~w_misaligned & ~w_sb_full;
    assign w_acc_load   = w_in_valid & w_idle & w_is_load & ~w_misaligned & w_sb_empty;
    assign w_acc_x      = w_in_valid & w_idle & ~w_is_mem;
    assign w_acc_direct = w_acc_mis | w_acc_store | w_acc_x;
    assign w_accept     = w_acc_direct | w_acc_load;

    assign stall       = w_in_valid & ~w_accept;
    assign sb_empty    = w_sb_empty;
    assign fwd_rf_wen  = w_in_valid & in_rf_wen;
    assign fwd_wb_addr = flush ? 5'd0 : in_wb_addr;

    // Draining stores own the bus whenever the FSM is idle.
    assign w_pop = w_idle & ~w_sb_empty & mem.mem_cmd_ready;

    // A load retires when its data beat arrives, unless it was flushed.
    assign w_load_retire = (r_state == S_DATA) & mem.mem_rdata_valid & ~(r_discard | flush);

    // Steer store data onto byte lanes with matching strobes.
    always_comb begin
        w_st_strb = 4'hF;
        w_st_data = in_wdata;
        if (w_is_byte) begin
            w_st_strb = 4'b0001 << w_lane;
            w_st_data = {4{in_wdata[7:0]}};
        end else if (w_is_half) begin
            w_st_strb = 4'b0011 << w_lane;
            w_st_data = {2{in_wdata[15:0]}};
        end
    end

    // Memory command mux: buffered store head first, then a load.
    always_comb begin
        mem.mem_cmd_start = 1'b0;
        mem.mem_cmd_write = 1'b0;
        mem.mem_addr      = '0;
        mem.mem_wdata     = '0;
        mem.mem_wstrb     = '0;
        case (r_state)
            S_IDLE: begin
                if (!w_sb_empty) begin
                    mem.mem_cmd_start = 1'b1;
                    mem.mem_cmd_write = 1'b1;
                    mem.mem_addr      = r_sb_addr[r_rd_ptr];
                    mem.mem_wdata     = r_sb_data[r_rd_ptr];
                    mem.mem_wstrb     = r_sb_strb[r_rd_ptr];
                end else if (w_acc_load) begin
                    mem.mem_cmd_start = 1'b1;
                    mem.mem_addr      = {in_addr[ADDR_W-1:2], 2'b00};
                end
            end
            S_REQ: begin
                mem.mem_cmd_start = 1'b1;
                mem.mem_addr      = {r_sv_addr[ADDR_W-1:2], 2'b00};
            end
            default: ;
        endcase
    end

    // Store buffer payload; contents are only meaningful between push and pop.
    always_ff @(posedge clk) begin
        if (w_acc_store) begin
            r_sb_addr[r_wr_ptr] <= {in_addr[ADDR_W-1:2], 2'b00};
            r_sb_data[r_wr_ptr] <= w_st_data;
            r_sb_strb[r_wr_ptr] <= w_st_strb;
        end
    end

    // Store buffer pointers and occupancy; pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_acc_store) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_pop)       r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            case ({w_acc_store, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Load FSM, discard tracking and the registered retire outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_discard      <= 1'b0;
            r_sv_pc        <= '0;
            r_sv_inst      <= '0;
            r_sv_addr      <= '0;
            r_sv_op        <= c_MEN_X;
            r_sv_rf_wen    <= 1'b0;
            r_sv_wb_sel    <= '0;
            r_sv_wb_addr   <= '0;
            out_valid      <= 1'b0;
            out_pc         <= REGPC_NOP;
            out_inst       <= INST_NOP;
            out_alu_out    <= '0;
            out_rdata      <= '0;
            out_misaligned <= 1'b0;
            out_rf_wen     <= 1'b0;
            out_wb_sel     <= '0;
            out_wb_addr    <= '0;
        end else begin
            out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_acc_load) begin
                        r_sv_pc      <= in_pc;
                        r_sv_inst    <= in_inst;
                        r_sv_addr    <= in_addr;
                        r_sv_op      <= in_mem_op;
                        r_sv_rf_wen  <= in_rf_wen;
                        r_sv_wb_sel  <= in_wb_sel;
                        r_sv_wb_addr <= in_wb_addr;
                        r_discard    <= 1'b0;
                        r_state      <= mem.mem_cmd_ready ? S_DATA : S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem.mem_cmd_ready) begin
                        r_state   <= S_DATA;
                        r_discard <= flush;
                    end else if (flush) begin
                        r_state <= S_IDLE;
                    end
                end
                S_DATA: begin
                    if (flush) r_discard <= 1'b1;
                    if (mem.mem_rdata_valid) begin
                        r_state   <= S_IDLE;
                        r_discard <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_load_retire) begin
                out_valid      <= 1'b1;
                out_pc         <= r_sv_pc;
                out_inst       <= r_sv_inst;
                out_alu_out    <= 32'(r_sv_addr);
                out_rdata      <= f_extract(r_sv_op, r_sv_addr[1:0], mem.mem_rdata);
                out_misaligned <= 1'b0;
                out_rf_wen     <= r_sv_rf_wen;
                out_wb_sel     <= r_sv_wb_sel;
                out_wb_addr    <= r_sv_wb_addr;
            end else if (w_acc_direct) begin
                out_valid      <= 1'b1;
                out_pc         <= in_pc;
                out_inst       <= in_inst;
                out_alu_out    <= 32'(in_addr);
                out_rdata      <= '0;
                out_misaligned <= w_acc_mis;
                out_rf_wen     <= w_acc_x & in_rf_wen;
                out_wb_sel     <= in_wb_sel;
                out_wb_addr    <= in_wb_addr;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_store_buffered.sv
`default_nettype none
//==============================================================================
// Module   : tb_lsu_store_buffered
// Brief    : Directed self-checking bench for lsu_store_buffered: a table of
//            single-op vectors plus hand-written multi-cycle sequences.
// Revision : 1.0 - initial release
//==============================================================================
module tb_lsu_store_buffered;

    localparam logic [3:0] MEN_X   = 4'd0;
    localparam logic [3:0] MEN_SB  = 4'd1;
    localparam logic [3:0] MEN_SH  = 4'd2;
    localparam logic [3:0] MEN_SW  = 4'd3;
    localparam logic [3:0] MEN_LB  = 4'd4;
    localparam logic [3:0] MEN_LBU = 4'd5;
    localparam logic [3:0] MEN_LH  = 4'd6;
    localparam logic [3:0] MEN_LHU = 4'd7;
    localparam logic [3:0] MEN_LW  = 4'd8;
    localparam logic [31:0] PC_NOP   = 32'h0000_0000;
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] resp;
        logic        exp_mis;
        logic        exp_rfw;
        logic [31:0] exp_rdata;
        logic [31:0] exp_maddr;
        logic [3:0]  exp_strb;
        logic [31:0] exp_mwdata;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_pc = '0, in_inst = '0, in_addr = '0, in_wdata = '0;
    logic [3:0]  in_mem_op = '0;
    logic        in_rf_wen = 1'b0;
    logic [3:0]  in_wb_sel = '0;
    logic [4:0]  in_wb_addr = '0;
    logic        stall, out_valid, out_misaligned, out_rf_wen, sb_empty, fwd_rf_wen;
    logic [31:0] out_pc, out_inst, out_alu_out, out_rdata;
    logic [3:0]  out_wb_sel;
    logic [4:0]  out_wb_addr, fwd_wb_addr;
    logic        mem_ready = 1'b1;
    logic [31:0] mem_rdata = '0;
    logic        mem_rvalid = 1'b0;

    int n_err = 0;
    int n_chk = 0;
    int n_rd  = 0;
    logic [31:0] wq[$];
    vec_t vt[13];

    always #5 clk = ~clk;

    lsu_store_buffered_if #(.ADDR_W(32)) mem_if ();
    assign mem_if.mem_cmd_ready   = mem_ready;
    assign mem_if.mem_rdata       = mem_rdata;
    assign mem_if.mem_rdata_valid = mem_rvalid;

    lsu_store_buffered #(
        .SB_DEPTH (4),
        .ADDR_W   (32),
        .REGPC_NOP(PC_NOP),
        .INST_NOP (INST_NOP)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_pc         (in_pc),
        .in_inst       (in_inst),
        .in_addr       (in_addr),
        .in_wdata      (in_wdata),
        .in_mem_op     (in_mem_op),
        .in_rf_wen     (in_rf_wen),
        .in_wb_sel     (in_wb_sel),
        .in_wb_addr    (in_wb_addr),
        .stall         (stall),
        .out_valid     (out_valid),
        .out_pc        (out_pc),
        .out_inst      (out_inst),
        .out_alu_out   (out_alu_out),
        .out_rdata     (out_rdata),
        .out_misaligned(out_misaligned),
        .out_rf_wen    (out_rf_wen),
        .out_wb_sel    (out_wb_sel),
        .out_wb_addr   (out_wb_addr),
        .sb_empty      (sb_empty),
        .fwd_rf_wen    (fwd_rf_wen),
        .fwd_wb_addr   (fwd_wb_addr),
        .mem           (mem_if)
    );

    // Records accepted write commands and counts accepted read commands.
    always @(negedge clk) begin
        if (mem_if.mem_cmd_start && mem_ready) begin
            if (mem_if.mem_cmd_write) wq.push_back(mem_if.mem_addr);
            else n_rd++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] pc);
        in_valid   = 1'b1;
        in_mem_op  = op;
        in_addr    = addr;
        in_wdata   = wdata;
        in_pc      = pc;
        in_inst    = pc ^ 32'h5500_0000;
        in_rf_wen  = 1'b1;
        in_wb_sel  = 4'h3;
        in_wb_addr = 5'd7;
    endtask

    // One table vector: accept, optional one-beat read response, retire.
    task automatic run_vec(input int i);
        vec_t v;
        logic ld, st;
        v  = vt[i];
        ld = (v.op >= MEN_LB) && (v.op <= MEN_LW);
        st = (v.op >= MEN_SB) && (v.op <= MEN_SW);
        @(posedge clk); #1;
        drive(v.op, v.addr, v.wdata, 32'h1000 + 32'(i * 4));
        in_wb_addr = 5'(i + 1);
        @(negedge clk);
        chk1($sformatf("v%0d_stall", i), stall, 1'b0);
        chk1($sformatf("v%0d_accept_cmd_start", i), mem_if.mem_cmd_start, ld & ~v.exp_mis);
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (ld && !v.exp_mis) begin
            mem_rdata  = v.resp;
            mem_rvalid = 1'b1;
            @(posedge clk); #1;
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
        end
        @(negedge clk);
        chk1($sformatf("v%0d_out_valid", i), out_valid, 1'b1);
        chk1($sformatf("v%0d_misaligned", i), out_misaligned, v.exp_mis);
        chk1($sformatf("v%0d_rf_wen", i), out_rf_wen, v.exp_rfw);
        chk($sformatf("v%0d_pc", i), out_pc, 32'h1000 + 32'(i * 4));
        chk($sformatf("v%0d_alu_out", i), out_alu_out, v.addr);
        chk($sformatf("v%0d_wb_addr", i), 32'(out_wb_addr), 32'(i + 1));
        if (ld && !v.exp_mis) chk($sformatf("v%0d_rdata", i), out_rdata, v.exp_rdata);
        if (st && !v.exp_mis) begin
            chk1($sformatf("v%0d_drain_start", i), mem_if.mem_cmd_start, 1'b1);
            chk1($sformatf("v%0d_drain_write", i), mem_if.mem_cmd_write, 1'b1);
            chk($sformatf("v%0d_maddr", i), mem_if.mem_addr, v.exp_maddr);
            chk($sformatf("v%0d_wstrb", i), 32'(mem_if.mem_wstrb), 32'(v.exp_strb));
            chk($sformatf("v%0d_mwdata", i), mem_if.mem_wdata, v.exp_mwdata);
            @(negedge clk);
        end else begin
            chk1($sformatf("v%0d_no_cmd", i), mem_if.mem_cmd_start, 1'b0);
        end
        chk1($sformatf("v%0d_sb_empty", i), sb_empty, 1'b1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        int rd_before;
        //            op       addr          wdata         resp          mis   rfw   rdata         maddr         strb     mwdata
        vt[0]  = '{MEN_SW,  32'h100, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 32'h0,        32'h100, 4'hF,    32'hDEADBEEF};
        vt[1]  = '{MEN_SB,  32'h103, 32'h0000005A, 32'h0,        1'b0, 1'b0, 32'h0,        32'h100, 4'b1000, 32'h5A5A5A5A};
        vt[2]  = '{MEN_LB,  32'h103, 32'h0,        32'h80000000, 1'b0, 1'b1, 32'hFFFFFF80, 32'h0,   4'h0,    32'h0};
        vt[3]  = '{MEN_LBU, 32'h103, 32'h0,        32'h80000000, 1'b0, 1'b1, 32'h00000080, 32'h0,   4'h0,    32'h0};
        vt[4]  = '{MEN_LH,  32'h102, 32'h0,        32'h80011234, 1'b0, 1'b1, 32'hFFFF8001, 32'h0,   4'h0,    32'h0};
        vt[5]  = '{MEN_LHU, 32'h102, 32'h0,        32'h80011234, 1'b0, 1'b1, 32'h00008001, 32'h0,   4'h0,    32'h0};
        vt[6]  = '{MEN_LH,  32'h100, 32'h0,        32'h1234F00D, 1'b0, 1'b1, 32'hFFFFF00D, 32'h0,   4'h0,    32'h0};
        vt[7]  = '{MEN_LW,  32'h104, 32'h0,        32'hCAFEBABE, 1'b0, 1'b1, 32'hCAFEBABE, 32'h0,   4'h0,    32'h0};
        vt[8]  = '{MEN_LW,  32'h102, 32'h0,        32'h0,        1'b1, 1'b0, 32'h0,        32'h0,   4'h0,    32'h0};
        vt[9]  = '{MEN_SH,  32'h101, 32'h1234,     32'h0,        1'b1, 1'b0, 32'h0,        32'h0,   4'h0,    32'h0};
        vt[10] = '{MEN_SH,  32'h202, 32'h1234BEEF, 32'h0,        1'b0, 1'b0, 32'h0,        32'h200, 4'b1100, 32'hBEEFBEEF};
        vt[11] = '{MEN_X,   32'h55,  32'h0,        32'h0,        1'b0, 1'b1, 32'h0,        32'h0,   4'h0,    32'h0};
        vt[12] = '{MEN_LB,  32'h101, 32'h0,        32'h00007F00, 1'b0, 1'b1, 32'h0000007F, 32'h0,   4'h0,    32'h0};

        // Reset values
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_pc", out_pc, PC_NOP);
        chk("rst_out_inst", out_inst, INST_NOP);
        chk("rst_out_rdata", out_rdata, 32'h0);
        chk1("rst_sb_empty", sb_empty, 1'b1);
        chk1("rst_cmd_start", mem_if.mem_cmd_start, 1'b0);
        chk1("rst_stall", stall, 1'b0);

        for (int i = 0; i < 13; i++) run_vec(i);

        // Fill the buffer with memory stalled, then a store and a load behind it
        wq.delete();
        @(posedge clk); #1 mem_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(MEN_SW, 32'h10 + 32'(k * 4), 32'(k), 32'h2000);
            @(negedge clk);
            chk1($sformatf("fill%0d_stall", k), stall, 1'b0);
            @(posedge clk); #1;
        end
        drive(MEN_SW, 32'h20, 32'h4, 32'h2000);
        @(negedge clk);
        chk1("full_stall", stall, 1'b1);
        chk1("full_sb_empty", sb_empty, 1'b0);
        @(posedge clk); #1 mem_ready = 1'b1;
        @(negedge clk);
        chk1("full_pop_same_cycle_stall", stall, 1'b1);
        chk("full_head_addr", mem_if.mem_addr, 32'h10);
        @(negedge clk);
        chk1("after_pop_accept", stall, 1'b0);
        @(posedge clk); #1;
        drive(MEN_LW, 32'h300, 32'h0, 32'h3000);
        waited = 0;
        @(negedge clk);
        chk1("load_behind_stores_stall", stall, 1'b1);
        while (stall && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk1("load_wait_bounded", waited < 20, 1'b1);
        chk("load_wait_cycles", 32'(waited), 32'd3);
        chk1("load_issue_sb_empty", sb_empty, 1'b1);
        chk1("load_issue_start", mem_if.mem_cmd_start, 1'b1);
        chk1("load_issue_read", mem_if.mem_cmd_write, 1'b0);
        chk("drain_count", 32'(wq.size()), 32'd5);
        for (int k = 0; k < 5; k++) begin
            logic [31:0] got;
            got = (k < wq.size()) ? wq[k] : 32'hFFFF_FFFF;
            chk($sformatf("drain_order%0d", k), got, 32'h10 + 32'(k * 4));
        end
        @(posedge clk); #1;
        in_valid   = 1'b0;
        mem_rdata  = 32'h11223344;
        mem_rvalid = 1'b1;
        @(posedge clk); #1 mem_rvalid = 1'b0;
        @(negedge clk);
        chk1("drained_load_valid", out_valid, 1'b1);
        chk("drained_load_rdata", out_rdata, 32'h11223344);
        chk("drained_load_pc", out_pc, 32'h3000);

        // Flush while the load waits for data
        @(posedge clk); #1 drive(MEN_LW, 32'h400, 32'h0, 32'h4000);
        @(negedge clk);
        chk1("flushdata_accept", stall, 1'b0);
        @(posedge clk); #1 in_valid = 1'b0; flush = 1'b1;
        @(negedge clk);
        chk1("flushdata_c0_valid", out_valid, 1'b0);
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        chk1("flushdata_c1_valid", out_valid, 1'b0);
        @(posedge clk); #1 mem_rdata = 32'h0BAD0BAD; mem_rvalid = 1'b1;
        @(negedge clk);
        chk1("flushdata_c2_valid", out_valid, 1'b0);
        @(posedge clk); #1 mem_rvalid = 1'b0; drive(MEN_X, 32'h77, 32'h0, 32'h7000);
        @(negedge clk);
        chk1("flushdata_no_retire", out_valid, 1'b0);
        chk1("flushdata_idle_accept", stall, 1'b0);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        chk1("flushdata_next_valid", out_valid, 1'b1);
        chk("flushdata_next_pc", out_pc, 32'h7000);

        // Flush while the load command is still waiting for ready
        rd_before = n_rd;
        @(posedge clk); #1 mem_ready = 1'b0; drive(MEN_LW, 32'h500, 32'h0, 32'h5000);
        @(negedge clk);
        chk1("flushreq_accept", stall, 1'b0);
        @(posedge clk); #1 drive(MEN_X, 32'h88, 32'h0, 32'h8000); in_wb_addr = 5'd9;
        @(negedge clk);
        chk1("flushreq_stall", stall, 1'b1);
        chk1("flushreq_redrive", mem_if.mem_cmd_start, 1'b1);
        chk1("fwd_rf_wen_live", fwd_rf_wen, 1'b1);
        chk("fwd_wb_addr_live", 32'(fwd_wb_addr), 32'd9);
        @(posedge clk); #1 flush = 1'b1;
        @(negedge clk);
        chk1("flushreq_stall_flush", stall, 1'b0);
        chk1("fwd_rf_wen_flush", fwd_rf_wen, 1'b0);
        chk("fwd_wb_addr_flush", 32'(fwd_wb_addr), 32'd0);
        @(posedge clk); #1 flush = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        chk1("flushreq_next_stall", stall, 1'b0);
        chk1("flushreq_no_cmd", mem_if.mem_cmd_start, 1'b0);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        chk1("flushreq_retire_valid", out_valid, 1'b1);
        chk("flushreq_retire_pc", out_pc, 32'h8000);
        chk("flushreq_no_read", 32'(n_rd), 32'(rd_before));

        // Reset during a load, with a stale response arriving afterwards
        @(posedge clk); #1 drive(MEN_LW, 32'h600, 32'h0, 32'h6000);
        @(posedge clk); #1 in_valid = 1'b0; rst_n = 1'b0;
        #2;
        chk("midrst_out_inst", out_inst, INST_NOP);
        chk1("midrst_sb_empty", sb_empty, 1'b1);
        @(posedge clk); #1 rst_n = 1'b1; mem_rdata = 32'h12345678; mem_rvalid = 1'b1;
        @(posedge clk); #1 mem_rvalid = 1'b0;
        @(negedge clk);
        chk1("midrst_stale_ignored", out_valid, 1'b0);
        chk1("midrst_no_cmd", mem_if.mem_cmd_start, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
